conv_pe_ctrl: RTL and testbench
===============================

CONV_PE_CTRL -- requirements
Module: conv_pe_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: ifmap, filter and multiplier operand width.
REQ-002 SHALL have parameter DEPTH_I, default 5: ifmap memory entries.
REQ-003 SHALL have parameter ADDR_I, default 3: ifmap address width.
REQ-004 SHALL have parameter DEPTH_F, default 3: filter memory entries.
REQ-005 SHALL have parameter ADDR_F, default 2: filter address width.
REQ-006 SHALL have parameter PSUM_W, default 16: accumulator and partial-sum output width.
REQ-007 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-009 SHALL have port start, input, 1: begin one 1-D convolution pass.
REQ-010 SHALL have port busy, output, 1: high from pass acceptance until done.
REQ-011 SHALL have port done, output, 1: one-cycle pulse ending a pass.
REQ-012 SHALL have ports if_rreq (out, 1), if_raddr (out, ADDR_I), if_rdata (in, WIDTH): ifmap memory read.
REQ-013 SHALL have ports f_rreq (out, 1), f_raddr (out, ADDR_F), f_rdata (in, WIDTH): filter memory read.
REQ-014 SHALL have ports mul_a, mul_b (out, WIDTH), mul_valid (out, 1), mul_ready (in, 1): multiplier operand handshake.
REQ-015 SHALL have ports mul_res (in, 2*WIDTH), mul_res_valid (in, 1): multiplier result return.
REQ-016 SHALL have ports psum_out (out, PSUM_W), psum_valid (out, 1), psum_ready (in, 1): output handshake.

Function
REQ-017 SHALL compute psum[o] = sum over j=0..DEPTH_F-1 of ifmap[o+j]*filter[j], for o=0..DEPTH_I-DEPTH_F, in ascending o.
REQ-018 SHALL implement FSM states IDLE, FETCH, LATCH, MUL, WAIT, OUT, DONE.
REQ-019 IDLE: start=1 -> FETCH next cycle; o=0, j=0, acc=0; busy rises in the same edge.
REQ-020 FETCH: assert if_rreq and f_rreq for exactly one cycle, if_raddr=o+j, f_raddr=j; -> LATCH.
REQ-021 LATCH: capture if_rdata and f_rdata (fixed one-cycle read latency); -> MUL.
REQ-022 MUL: drive mul_valid with latched operands; operands stable while mul_valid=1 and mul_ready=0; transfer when both high -> WAIT.
REQ-023 WAIT: on mul_res_valid, acc += mul_res zero-extended; if j=DEPTH_F-1 -> OUT, else j++ and -> FETCH; mul_res_valid outside WAIT ignored.
REQ-024 OUT: psum_valid=1, psum_out=acc, both stable until psum_ready; on transfer: if o=DEPTH_I-DEPTH_F -> DONE, else o++, j=0, acc=0, -> FETCH.
REQ-025 DONE: done=1 for one cycle, busy falls; -> IDLE.
REQ-026 start outside IDLE SHALL be ignored; start in DONE is ignored.
REQ-027 All arithmetic unsigned; accumulator wraps modulo 2^PSUM_W unless REQ-032 applies.
REQ-028 Per-output latency with always-ready handshakes SHALL be 4*DEPTH_F+1 cycles (OUT included).

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, o=j=acc=0, and all outputs (busy, done, rreqs, addresses, mul_a/b, mul_valid, psum_out, psum_valid) to 0.
REQ-030 Reset mid-pass SHALL abandon the pass with no psum or done emitted; first edge after rst falls samples start normally.

Configuration
REQ-031 Macro CONV_PE_PSUM_SAT_EN SHALL select accumulator overflow behaviour.
REQ-032 Defined: acc saturates at 2^PSUM_W-1 and stays there for that output; undefined: wrap modulo 2^PSUM_W.

Verification
REQ-033 ifmap={0,1,2,3,4}, filter={0,1,2}, start pulse, ready always high -> psum 5, 8, 11 in order, then one done pulse.
REQ-034 Same data, psum_ready low 5 cycles at first OUT -> psum_valid held, psum_out stable at 5, no extra reads.
REQ-035 mul_ready low 3 cycles in MUL -> mul_valid, mul_a, mul_b held constant; results unchanged (5, 8, 11).
REQ-036 start pulsed during busy -> ignored; exactly three psums and one done.
REQ-037 rst asserted after first psum -> all outputs 0 immediately, no further psum/done; new start yields 5, 8, 11.
REQ-038 ifmap all 255, filter all 255, PSUM_W=16 -> psum 64003 each without CONV_PE_PSUM_SAT_EN, 65535 each with it.

Source files
------------

// File: rtl/conv_pe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_pe_ctrl
// Description : Controller for a 1-D convolution processing element. For each
//               output position o it walks the filter taps j, reads one
//               ifmap word and one filter word per tap, hands the pair to an
//               external multiplier, accumulates the returned products and
//               presents the finished partial sum on a valid/ready port.
//               psum[o] = sum_j ifmap[o+j] * filter[j],
//               o = 0 .. DEPTH_I-DEPTH_F, in ascending order.
// Ports       : clk, rst (async, active-high)
//               start            - begin one pass (sampled only when idle)
//               busy / done      - pass in progress / one-cycle end pulse
//               if_rreq/if_raddr/if_rdata - ifmap memory read (1-cycle latency)
//               f_rreq/f_raddr/f_rdata    - filter memory read (1-cycle latency)
//               mul_a/mul_b/mul_valid/mul_ready - multiplier operand handshake
//               mul_res/mul_res_valid     - multiplier result return
//               psum_out/psum_valid/psum_ready  - partial-sum output handshake
// Config      : `define CONV_PE_PSUM_SAT_EN to saturate the accumulator at
//               2^PSUM_W-1 instead of wrapping modulo 2^PSUM_W.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_pe_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DEPTH_I = 5,
  parameter int ADDR_I  = 3,
  parameter int DEPTH_F = 3,
  parameter int ADDR_F  = 2,
  parameter int PSUM_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 if_rreq,
  output logic [ADDR_I-1:0]    if_raddr,
  input  logic [WIDTH-1:0]     if_rdata,
  output logic                 f_rreq,
  output logic [ADDR_F-1:0]    f_raddr,
  input  logic [WIDTH-1:0]     f_rdata,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_valid,
  input  logic                 mul_ready,
  input  logic [2*WIDTH-1:0]   mul_res,
  input  logic                 mul_res_valid,
  output logic [PSUM_W-1:0]    psum_out,
  output logic                 psum_valid,
  input  logic                 psum_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    MUL   = 3'd3,
    WAIT  = 3'd4,
    OUT   = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [ADDR_I-1:0] c_O_LAST = ADDR_I'(DEPTH_I - DEPTH_F);
  localparam logic [ADDR_F-1:0] c_J_LAST = ADDR_F'(DEPTH_F - 1);

  state_t             r_state, w_state_nxt;
  logic [ADDR_I-1:0]  r_o, w_o_nxt;
  logic [ADDR_F-1:0]  r_j, w_j_nxt;
  logic [PSUM_W-1:0]  r_acc, w_acc_nxt;
  logic [WIDTH-1:0]   r_a, w_a_nxt;
  logic [WIDTH-1:0]   r_b, w_b_nxt;
  logic [PSUM_W-1:0]  w_acc_add;

`ifdef CONV_PE_PSUM_SAT_EN
  // One guard bit above the wider of the two addends so an overflow is seen
  // before it is clipped; once at the ceiling every later add stays clipped.
  localparam int c_SUM_W = ((PSUM_W > 2*WIDTH) ? PSUM_W : 2*WIDTH) + 1;
  localparam logic [PSUM_W-1:0] c_ACC_MAX = {PSUM_W{1'b1}};
  logic [c_SUM_W-1:0] w_sum;
  assign w_sum     = c_SUM_W'(r_acc) + c_SUM_W'(mul_res);
  assign w_acc_add = (w_sum > c_SUM_W'(c_ACC_MAX)) ? c_ACC_MAX : w_sum[PSUM_W-1:0];
`else
  assign w_acc_add = r_acc + PSUM_W'(mul_res);
`endif

  // Operands come straight from the latch registers, so they cannot move
  // while the multiplier stalls.
  assign mul_a    = r_a;
  assign mul_b    = r_b;
  assign psum_out = r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_o     <= '0;
      r_j     <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_o     <= w_o_nxt;
      r_j     <= w_j_nxt;
      r_acc   <= w_acc_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_o_nxt     = r_o;
    w_j_nxt     = r_j;
    w_acc_nxt   = r_acc;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    busy        = 1'b0;
    done        = 1'b0;
    if_rreq     = 1'b0;
    f_rreq      = 1'b0;
    if_raddr    = '0;
    f_raddr     = '0;
    mul_valid   = 1'b0;
    psum_valid  = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = FETCH;
          w_o_nxt     = '0;
          w_j_nxt     = '0;
          w_acc_nxt   = '0;
        end
      end
      FETCH: begin
        busy        = 1'b1;
        if_rreq     = 1'b1;
        f_rreq      = 1'b1;
        if_raddr    = r_o + ADDR_I'(r_j);
        f_raddr     = r_j;
        w_state_nxt = LATCH;
      end
      LATCH: begin
        busy        = 1'b1;
        w_a_nxt     = if_rdata;
        w_b_nxt     = f_rdata;
        w_state_nxt = MUL;
      end
      MUL: begin
        busy      = 1'b1;
        mul_valid = 1'b1;
        if (mul_ready) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (mul_res_valid) begin
          w_acc_nxt = w_acc_add;
          if (r_j == c_J_LAST) begin
            w_state_nxt = OUT;
          end else begin
            w_j_nxt     = r_j + 1'b1;
            w_state_nxt = FETCH;
          end
        end
      end
      OUT: begin
        busy       = 1'b1;
        psum_valid = 1'b1;
        if (psum_ready) begin
          if (r_o == c_O_LAST) begin
            w_state_nxt = DONE;
          end else begin
            w_o_nxt     = r_o + 1'b1;
            w_j_nxt     = '0;
            w_acc_nxt   = '0;
            w_state_nxt = FETCH;
          end
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_pe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_pe_ctrl
// Description : Self-checking bench for conv_pe_ctrl. Behavioural ifmap and
//               filter memories plus a multiplier model surround the DUT.
//               Expected multiplier operands and partial sums are queued when
//               a pass is started; a negedge monitor pops and compares them
//               whenever the DUT transfers on its handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_pe_ctrl;
  localparam int WIDTH   = 8;
  localparam int DEPTH_I = 5;
  localparam int ADDR_I  = 3;
  localparam int DEPTH_F = 3;
  localparam int ADDR_F  = 2;
  localparam int PSUM_W  = 16;
  localparam int N_OUT   = DEPTH_I - DEPTH_F + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                busy, done;
  logic                if_rreq, f_rreq;
  logic [ADDR_I-1:0]   if_raddr;
  logic [ADDR_F-1:0]   f_raddr;
  logic [WIDTH-1:0]    if_rdata, f_rdata;
  logic [WIDTH-1:0]    mul_a, mul_b;
  logic                mul_valid;
  logic                mul_ready = 1'b1;
  logic [2*WIDTH-1:0]  mul_res;
  logic                mul_res_valid;
  logic [PSUM_W-1:0]   psum_out;
  logic                psum_valid;
  logic                psum_ready = 1'b1;

  conv_pe_ctrl #(
    .WIDTH(WIDTH), .DEPTH_I(DEPTH_I), .ADDR_I(ADDR_I),
    .DEPTH_F(DEPTH_F), .ADDR_F(ADDR_F), .PSUM_W(PSUM_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .if_rreq(if_rreq), .if_raddr(if_raddr), .if_rdata(if_rdata),
    .f_rreq(f_rreq), .f_raddr(f_raddr), .f_rdata(f_rdata),
    .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid), .mul_ready(mul_ready),
    .mul_res(mul_res), .mul_res_valid(mul_res_valid),
    .psum_out(psum_out), .psum_valid(psum_valid), .psum_ready(psum_ready)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0]    if_mem [DEPTH_I];
  logic [WIDTH-1:0]    f_mem  [DEPTH_F];
  logic [PSUM_W-1:0]   psum_q [$];
  logic [2*WIDTH-1:0]  op_q   [$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int psum_cnt = 0;
  int rdy_mode = 0;
  int junk_en = 0;
  bit lat_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- memory and multiplier models ----------------
  // Requests are sampled mid-cycle, answered on the following rising edge.
  logic               rd_if, rd_f, mul_fire;
  logic [ADDR_I-1:0]  rd_ia;
  logic [ADDR_F-1:0]  rd_fa;
  logic [2*WIDTH-1:0] mul_prod;

  always @(negedge clk) begin
    rd_if    = if_rreq;
    rd_f     = f_rreq;
    rd_ia    = if_raddr;
    rd_fa    = f_raddr;
    mul_fire = mul_valid && mul_ready;
    mul_prod = mul_a * mul_b;
  end

  always @(posedge clk) begin
    if_rdata <= (rd_if && int'(rd_ia) < DEPTH_I) ? if_mem[rd_ia] : WIDTH'($urandom);
    f_rdata  <= (rd_f && int'(rd_fa) < DEPTH_F) ? f_mem[rd_fa] : WIDTH'($urandom);
    if (mul_fire) begin
      mul_res_valid <= 1'b1;
      mul_res       <= mul_prod;
    end else if (junk_en != 0 && $urandom_range(3) == 0) begin
      mul_res_valid <= 1'b1;
      mul_res       <= (2*WIDTH)'($urandom);
    end else begin
      mul_res_valid <= 1'b0;
      mul_res       <= (2*WIDTH)'($urandom);
    end
  end

  // ---------------- monitor ----------------
  logic               mv_stall = 1'b0, pv_stall = 1'b0;
  logic [WIDTH-1:0]   last_a, last_b;
  logic [PSUM_W-1:0]  last_psum;
  logic [PSUM_W-1:0]  exp_p;
  logic [2*WIDTH-1:0] exp_op;
  int cyc = 0;
  int last_xfer = -1;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mv_stall  = 1'b0;
      pv_stall  = 1'b0;
      last_xfer = -1;
    end else begin
      if (mv_stall) begin
        check("mul_valid_hold", mul_valid, 1);
        check("mul_a_hold", mul_a, last_a);
        check("mul_b_hold", mul_b, last_b);
      end
      if (mul_valid && mul_ready) begin
        if (op_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mul_unexpected: got a=%0d b=%0d expected no operation", mul_a, mul_b);
        end else begin
          exp_op = op_q.pop_front();
          check("mul_operands", {mul_a, mul_b}, exp_op);
        end
      end
      mv_stall = mul_valid && !mul_ready;
      last_a   = mul_a;
      last_b   = mul_b;

      if (pv_stall) begin
        check("psum_valid_hold", psum_valid, 1);
        check("psum_out_hold", psum_out, last_psum);
      end
      if (psum_valid) check("no_read_in_out", {if_rreq, f_rreq}, 0);
      if (psum_valid && psum_ready) begin
        psum_cnt++;
        if (psum_q.size() == 0) begin
          total++; bad++;
          $display("FAIL psum_unexpected: got %0d expected no psum", psum_out);
        end else begin
          exp_p = psum_q.pop_front();
          check("psum_value", psum_out, exp_p);
        end
        if (lat_chk && last_xfer >= 0) check("psum_interval", cyc - last_xfer, 4*DEPTH_F + 1);
        last_xfer = cyc;
      end
      pv_stall  = psum_valid && !psum_ready;
      last_psum = psum_out;

      if (done) begin
        done_cnt++;
        check("done_after_psums", psum_q.size(), 0);
        last_xfer = -1;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [PSUM_W-1:0] ref_psum(input int o);
    longint s = 0;
    for (int j = 0; j < DEPTH_F; j++) s += longint'(if_mem[o+j]) * longint'(f_mem[j]);
`ifdef CONV_PE_PSUM_SAT_EN
    if (s > (longint'(1) << PSUM_W) - 1) s = (longint'(1) << PSUM_W) - 1;
`endif
    return PSUM_W'(s);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_mode == 1) begin
      mul_ready  = ($urandom_range(2) != 0);
      psum_ready = ($urandom_range(2) != 0);
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < DEPTH_I; i++) if_mem[i] = WIDTH'(i);
    for (int j = 0; j < DEPTH_F; j++) f_mem[j] = WIDTH'(j);
  endtask

  task automatic start_pass();
    for (int o = 0; o < N_OUT; o++) begin
      for (int j = 0; j < DEPTH_F; j++) op_q.push_back({if_mem[o+j], f_mem[j]});
      psum_q.push_back(ref_psum(o));
    end
    exp_done++;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt < exp_done && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done"}, done_cnt, exp_done);
    check({name, "_drained"}, psum_q.size(), 0);
    tick();
    check({name, "_idle_busy"}, busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {busy, done, if_rreq, f_rreq, mul_valid, psum_valid}, 0);
    check({name, "_addr"}, {if_raddr, f_raddr}, 0);
    check({name, "_mul_ab"}, {mul_a, mul_b}, 0);
    check({name, "_psum_out"}, psum_out, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int p0;
    set_ramp();
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // Ramp data, always-ready: 5, 8, 11 with fixed per-output latency.
    lat_chk = 1'b1;
    start_pass();
    wait_done("ramp", 200);
    lat_chk = 1'b0;

    // Output stalled 5 cycles at first OUT.
    psum_ready = 1'b0;
    start_pass();
    n = 0;
    while (!psum_valid && n < 100) begin tick(); n++; end
    check("oready_reach_out", psum_valid, 1);
    repeat (5) tick();
    check("oready_held_value", psum_out, psum_q[0]);
    psum_ready = 1'b1;
    wait_done("oready", 200);

    // Multiplier stalled 3 cycles.
    mul_ready = 1'b0;
    start_pass();
    n = 0;
    while (!mul_valid && n < 100) begin tick(); n++; end
    check("mready_reach_mul", mul_valid, 1);
    repeat (3) tick();
    mul_ready = 1'b1;
    wait_done("mready", 200);

    // Start pulses while busy are ignored.
    p0 = psum_cnt;
    start_pass();
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done("busy_start", 200);
    repeat (30) tick();
    check("busy_start_psums", psum_cnt - p0, N_OUT);
    check("busy_start_no_extra_done", done_cnt, exp_done);

    // Reset after the first psum abandons the pass.
    p0 = psum_cnt;
    start_pass();
    n = 0;
    while (psum_cnt == p0 && n < 100) begin tick(); n++; end
    check("rst_mid_first_psum", psum_cnt - p0, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid");
    psum_q.delete();
    op_q.delete();
    exp_done = done_cnt;
    tick(); tick();
    rst = 1'b0;
    repeat (30) tick();
    check("rst_mid_no_done", done_cnt, exp_done);
    start_pass();
    wait_done("after_rst", 200);

    // Full-scale data: wraps (or saturates) the accumulator.
    for (int i = 0; i < DEPTH_I; i++) if_mem[i] = '1;
    for (int j = 0; j < DEPTH_F; j++) f_mem[j] = '1;
    start_pass();
    wait_done("full_scale", 200);

    // Randomized data, handshakes and stray multiplier results.
    rdy_mode = 1;
    junk_en  = 1;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < DEPTH_I; i++) if_mem[i] = WIDTH'($urandom);
      for (int j = 0; j < DEPTH_F; j++) f_mem[j] = WIDTH'($urandom);
      start_pass();
      wait_done("random", 2000);
    end
    rdy_mode   = 0;
    junk_en    = 0;
    mul_ready  = 1'b1;
    psum_ready = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
